// File: rtl/femto_pkg.sv
// Shared opcodes and instruction-field geometry for the femto_pipe core.
// Field positions are functions of NUMRF so every file agrees on the encoding.
package femto_pkg;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_LDI = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_MOV = 3'd6;
   localparam logic [2:0] OP_OUT = 3'd7;

   localparam int RD_LO = 3;

   function automatic int instr_width(input int numrf);
      return 3 + 2 * numrf;
   endfunction

   function automatic int rd_hi(input int numrf);
      return 2 + numrf;
   endfunction

   function automatic int rs_lo(input int numrf);
      return 3 + numrf;
   endfunction

   function automatic int rs_hi(input int numrf);
      return 2 + 2 * numrf;
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/femto_pipe_if.sv
// Instruction stream and display/flag outputs of the femto_pipe core.
// master = instruction source / display consumer, slave = the core.
interface femto_pipe_if
   import femto_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NUMRF = 2
);
   localparam int INSTR_W = instr_width(NUMRF);
   localparam int DIGITS  = ceil_div(WIDTH, 4);

   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic [6:0]         seg;
   logic [DIGITS-1:0]  digit;
   logic               flag_z;
   logic               flag_c;
   logic               out_valid;

   modport master (
      output instr_valid, instr,
      input  seg, digit, flag_z, flag_c, out_valid
   );

   modport slave (
      input  instr_valid, instr,
      output seg, digit, flag_z, flag_c, out_valid
   );
endinterface

// File: rtl/femto_seg7_dec.sv
// Combinational hex nibble to 7-segment glyph, bit order gfedcba, active-high.
module femto_seg7_dec (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'b0000000;
      case (nibble)
         4'h0: seg = 7'b0111111;
         4'h1: seg = 7'b0000110;
         4'h2: seg = 7'b1011011;
         4'h3: seg = 7'b1001111;
         4'h4: seg = 7'b1100110;
         4'h5: seg = 7'b1101101;
         4'h6: seg = 7'b1111101;
         4'h7: seg = 7'b0000111;
         4'h8: seg = 7'b1111111;
         4'h9: seg = 7'b1101111;
         4'ha: seg = 7'b1110111;
         4'hb: seg = 7'b1111100;
         4'hc: seg = 7'b0111001;
         4'hd: seg = 7'b1011110;
         4'he: seg = 7'b1111001;
         4'hf: seg = 7'b1110001;
         default: seg = 7'b0000000;
      endcase
   end
endmodule

// File: rtl/femto_pipe.sv
// femto_pipe: two-stage register-file core with forwarding, Z/C flags and a
// scanned multi-digit display. FEMTO_SEG7_EN selects glyph vs raw-nibble seg.
module femto_pipe
   import femto_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NUMRF = 2,
   parameter int DIV_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   femto_pipe_if.slave bus
);
   localparam int DIGITS = ceil_div(WIDTH, 4);
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int NREG   = 2 ** NUMRF;
   localparam int RD_HI  = rd_hi(NUMRF);
   localparam int RS_LO  = rs_lo(NUMRF);
   localparam int RS_HI  = rs_hi(NUMRF);

   logic [WIDTH-1:0] rf [NREG];
   logic [WIDTH-1:0] out_reg;
   logic             flag_z, flag_c, out_valid;

   logic             s1_valid;
   logic [2:0]       s1_op;
   logic [NUMRF-1:0] s1_rd, s1_rs;
   logic [WIDTH-1:0] s1_a, s1_b;

   logic [2:0]       op;
   logic [NUMRF-1:0] rd, rs;
   logic [WIDTH-1:0] a_in, b_in;

   logic [WIDTH-1:0] res;
   logic [WIDTH:0]   sum, diff;
   logic             wr_en, flag_wr, out_wr, z_n, c_n;

   logic [DIV_W-1:0]    presc;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] out_pad;
   logic [3:0]          nibble;
   logic [6:0]          seg_w;

   assign op = bus.instr[2:0];
   assign rd = bus.instr[RD_HI:RD_LO];
   assign rs = bus.instr[RS_HI:RS_LO];

   // Execute/writeback stage operating on the captured stage register.
   always_comb begin
      res     = '0;
      wr_en   = 1'b0;
      flag_wr = 1'b0;
      out_wr  = 1'b0;
      z_n     = flag_z;
      c_n     = flag_c;
      sum     = {1'b0, s1_a} + {1'b0, s1_b};
      diff    = {1'b0, s1_a} - {1'b0, s1_b};
      if (s1_valid) begin
         case (s1_op)
            OP_LDI: begin res = {s1_a[WIDTH-1-NUMRF:0], s1_rs}; wr_en = 1'b1; end
            OP_ADD: begin res = sum[WIDTH-1:0];  c_n = sum[WIDTH];  wr_en = 1'b1; flag_wr = 1'b1; end
            OP_SUB: begin res = diff[WIDTH-1:0]; c_n = diff[WIDTH]; wr_en = 1'b1; flag_wr = 1'b1; end
            OP_AND: begin res = s1_a & s1_b; c_n = 1'b0; wr_en = 1'b1; flag_wr = 1'b1; end
            OP_XOR: begin res = s1_a ^ s1_b; c_n = 1'b0; wr_en = 1'b1; flag_wr = 1'b1; end
            OP_MOV: begin res = s1_b; wr_en = 1'b1; end
            OP_OUT: out_wr = 1'b1;
            default: ;
         endcase
         if (flag_wr)
            z_n = (res == '0);
      end
   end

   // Operand capture forwards the result that commits on the same edge.
   always_comb begin
      a_in = rf[rd];
      b_in = rf[rs];
      if (wr_en && (s1_rd == rd))
         a_in = res;
      if (wr_en && (s1_rd == rs))
         b_in = res;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            rf[i] <= '0;
         out_reg   <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         out_valid <= 1'b0;
         s1_valid  <= 1'b0;
         s1_op     <= OP_NOP;
         s1_rd     <= '0;
         s1_rs     <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         presc     <= '0;
         idx       <= '0;
      end else begin
         s1_valid <= bus.instr_valid;
         if (bus.instr_valid) begin
            s1_op <= op;
            s1_rd <= rd;
            s1_rs <= rs;
            s1_a  <= a_in;
            s1_b  <= b_in;
         end
         if (wr_en)
            rf[s1_rd] <= res;
         if (flag_wr) begin
            flag_z <= z_n;
            flag_c <= c_n;
         end
         if (out_wr)
            out_reg <= s1_b;
         out_valid <= out_wr;

         presc <= presc + DIV_W'(1);
         if (presc == '1)
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
   end

   // Nibbles above WIDTH read as zero.
   always_comb begin
      out_pad = '0;
      out_pad[WIDTH-1:0] = out_reg;
   end

   assign nibble = out_pad[4*idx +: 4];

`ifdef FEMTO_SEG7_EN
   femto_seg7_dec u_seg7_dec (
      .nibble (nibble),
      .seg    (seg_w)
   );
`else
   assign seg_w = {3'b000, nibble};
`endif

   assign bus.seg       = seg_w;
   assign bus.digit     = DIGITS'(1) << idx;
   assign bus.flag_z    = flag_z;
   assign bus.flag_c    = flag_c;
   assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_femto_pipe.sv
// Directed bench for femto_pipe (WIDTH=8, NUMRF=2, DIV_W=2) with a register
// model and a queue of expected display values consumed on each OUT commit.
module tb_femto_pipe;
   import femto_pkg::*;

   localparam int W  = 8;
   localparam int N  = 2;
   localparam int DW = 2;

   logic clk, rst;

   femto_pipe_if #(.WIDTH(W), .NUMRF(N)) bus ();

   femto_pipe #(.WIDTH(W), .NUMRF(N), .DIV_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] m_rf [4];
   logic       m_z, m_c;
   logic [7:0] exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] glyph(input logic [3:0] n);
`ifdef FEMTO_SEG7_EN
      case (n)
         4'h0: return 7'b0111111;
         4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'ha: return 7'b1110111;
         4'hb: return 7'b1111100;
         4'hc: return 7'b0111001;
         4'hd: return 7'b1011110;
         4'he: return 7'b1111001;
         default: return 7'b1110001;
      endcase
`else
      return {3'b000, n};
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
      m_z = 1'b0;
      m_c = 1'b0;
   endtask

   // Drive one instruction for exactly one sampling edge and advance the model.
   task automatic step(input logic [2:0] op, input int rd, input int rs);
      logic [8:0] t;
      logic [7:0] a, b, r;
      a = m_rf[rd];
      b = m_rf[rs];
      case (op)
         OP_LDI: m_rf[rd] = {a[5:0], 2'(rs)};
         OP_ADD: begin t = {1'b0, a} + {1'b0, b}; m_rf[rd] = t[7:0]; m_c = t[8]; m_z = (t[7:0] == 8'h00); end
         OP_SUB: begin r = a - b; m_rf[rd] = r; m_c = (a < b); m_z = (r == 8'h00); end
         OP_AND: begin r = a & b; m_rf[rd] = r; m_c = 1'b0; m_z = (r == 8'h00); end
         OP_XOR: begin r = a ^ b; m_rf[rd] = r; m_c = 1'b0; m_z = (r == 8'h00); end
         OP_MOV: m_rf[rd] = b;
         default: ;
      endcase
      bus.instr       = {2'(rs), 2'(rd), op};
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_z"}, 32'(bus.flag_z), 32'(m_z));
      chk({tag, "_c"}, 32'(bus.flag_c), 32'(m_c));
   endtask

   // OUT rs, then confirm the pulse and every scanned digit of the display.
   task automatic show(input int rs, input string tag);
      logic [7:0] v;
      logic       found;
      exp_q.push_back(m_rf[rs]);
      step(OP_OUT, 0, rs);
      @(negedge clk);
      chk({tag, "_ov_pulse"}, 32'(bus.out_valid), 32'd1);
      v = exp_q.pop_front();
      @(negedge clk);
      chk({tag, "_ov_once"}, 32'(bus.out_valid), 32'd0);
      for (int d = 0; d < 2; d++) begin
         found = 1'b0;
         for (int k = 0; k < 16 && !found; k++) begin
            if (bus.digit === 2'(1 << d)) found = 1'b1;
            else @(negedge clk);
         end
         chk({tag, "_digit_seen"}, 32'(found), 32'd1);
         chk({tag, "_seg"}, 32'(bus.seg), 32'(glyph(v[4*d +: 4])));
      end
   endtask

   initial begin
      logic [1:0] prevd;
      logic       found, seen;

      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_seg",   32'(bus.seg),       32'(glyph(4'h0)));
      chk("rst_digit", 32'(bus.digit),     32'd1);
      chk("rst_z",     32'(bus.flag_z),    32'd0);
      chk("rst_c",     32'(bus.flag_c),    32'd0);
      chk("rst_ov",    32'(bus.out_valid), 32'd0);

      // Immediate shift-in, back to back on the same register.
      step(OP_LDI, 1, 2);
      step(OP_LDI, 1, 3);
      settle();
      show(1, "ldi");
      step(OP_ADD, 1, 1);
      settle();
      chk_flags("add");
      show(1, "add");

      // Scan timing: 4 cycles per digit, wrapping after two digits.
      prevd = bus.digit;
      found = 1'b0;
      for (int k = 0; k < 16 && !found; k++) begin
         @(negedge clk);
         if (bus.digit === 2'b01 && prevd !== 2'b01) found = 1'b1;
         prevd = bus.digit;
      end
      chk("scan_wrap_seen", 32'(found), 32'd1);
      chk("scan_d0_seg", 32'(bus.seg), 32'(glyph(4'h6)));
      repeat (4) @(negedge clk);
      chk("scan_d1",     32'(bus.digit), 32'd2);
      chk("scan_d1_seg", 32'(bus.seg),   32'(glyph(4'h1)));
      repeat (4) @(negedge clk);
      chk("scan_back_d0", 32'(bus.digit), 32'd1);

      // Dependent chain with no gaps: LDI -> ADD -> OUT all on r0.
      step(OP_LDI, 0, 3);
      step(OP_ADD, 0, 0);
      show(0, "fwd");
      chk_flags("fwd");

      step(OP_SUB, 2, 0);
      settle();
      chk_flags("sub");
      show(2, "sub");
      step(OP_AND, 2, 0);
      settle();
      chk_flags("and");
      step(OP_XOR, 2, 2);
      settle();
      chk_flags("xor");
      show(2, "xor");

      // Overflow to zero, then MOV must preserve both flags.
      repeat (4) step(OP_LDI, 3, 3);
      repeat (3) step(OP_LDI, 0, 0);
      step(OP_LDI, 0, 1);
      step(OP_ADD, 3, 0);
      settle();
      chk_flags("ovf");
      step(OP_MOV, 2, 0);
      settle();
      chk_flags("mov");
      show(3, "ovf");
      show(2, "mov");

      // OUT in flight, then reset on the same edge as an ADD: both discarded.
      bus.instr       = {2'd1, 2'd0, OP_OUT};
      bus.instr_valid = 1'b1;
      @(negedge clk);
      rst       = 1'b1;
      bus.instr = {2'd1, 2'd1, OP_ADD};
      @(negedge clk);
      rst             = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      model_reset();
      chk("mid_rst_ov",    32'(bus.out_valid), 32'd0);
      chk("mid_rst_digit", 32'(bus.digit),     32'd1);
      chk("mid_rst_seg",   32'(bus.seg),       32'(glyph(4'h0)));
      chk("mid_rst_z",     32'(bus.flag_z),    32'd0);
      chk("mid_rst_c",     32'(bus.flag_c),    32'd0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen = 1'b1;
      end
      chk("mid_rst_no_ov", 32'(seen), 32'd0);
      show(1, "rst_r1");
      show(3, "rst_r3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/femto_pipe.md
# femto_pipe

Second-generation femto processor core: a parametrised register-file machine with a two-stage (capture / execute-writeback) pipeline, operand forwarding, Z/C flags, shift-in immediates for any data width, and a time-multiplexed multi-digit 7-segment output. It sits behind the 8-pin TinyTapeout wrapper, which maps clock, reset, instruction strobe and instruction bits from `io_in`. It drives the segment/digit pins on `io_out`. It supersedes the single-digit, reset-less 4-bit femto top.

## Interface
- `WIDTH`, 8: data/register width in bits (4..16).
- `NUMRF`, 2: log2 of register count.
- `DIV_W`, 10: the display digit advances every 2**DIV_W cycles.
- Derived: `INSTR_W` = 3+2*NUMRF; `DIGITS` = ceil(WIDTH/4).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instr is sampled this edge; no ready, never stalls.
- `instr`  in  INSTR_W  [2:0] op, [2+NUMRF:3] rd, [INSTR_W-1:3+NUMRF] rs.
- `seg`  out  7  segment bus, gfedcba, active-high.
- `digit`  out  DIGITS  one-hot digit enable.
- `flag_z`  out  1  zero flag.
- `flag_c`  out  1  carry/borrow flag.
- `out_valid`  out  1  one-cycle pulse after OUT writes the display register.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd <= {rd[WIDTH-1-NUMRF:0], rs_field}. The rs field is the immediate, shifted in NUMRF bits per instruction.
  - 2 ADD: rd <= rd+rs.
  - 3 SUB: rd <= rd-rs.
  - 4 AND.
  - 5 XOR.
  - 6 MOV: rd <= rs.
  - 7 OUT: out_reg <= rs.
- All arithmetic is modulo 2**WIDTH.
- ADD: C = carry-out. SUB: C = borrow (rd<rs unsigned).
- Z = (result==0) for ADD/SUB/AND/XOR. AND/XOR clear C.
- NOP, LDI, MOV and OUT leave both flags unchanged.
- Stage 1 (edge N, instr_valid=1): latch op, rd, rs_field and both operands into the stage register; set s1_valid.
- Stage 2 (edge N+1, s1_valid=1): ALU result is written to rd, flags, or out_reg.
- Forwarding: if the stage-1 instruction reads a register that the in-flight stage-2 instruction writes, it takes the stage-2 result instead of the file value.
  - This applies to LDI/ADD/SUB/AND/XOR/MOV destinations.
  - Back-to-back dependent instructions therefore never see stale data.
- Display: a free-running DIV_W-bit prescaler plus a digit index 0..DIGITS-1, wrapping to 0.
  - `digit` is one-hot on the index.
  - seg shows nibble [4*idx+3:4*idx] of out_reg. Upper nibble bits beyond WIDTH read 0.
- Reset (rst=1 at an edge):
  - All registers, out_reg, flags, s1_valid, prescaler and digit index go to 0.
  - Any instruction in flight or sampled that edge is discarded.
  - Outputs after reset: seg = glyph of 0, digit = 1 (LSB), flag_z = 0, flag_c = 0, out_valid = 0.

## Timing
- Latency: an instruction sampled at edge N updates registers, flags and out_reg at edge N+1. Results are visible on outputs in cycle N+1.
- Throughput: one instruction per cycle. No bubbles are needed.
- out_valid is high for exactly the cycle following the edge where OUT committed.
- A rst edge coinciding with an instruction edge means the instruction has no effect.
- A display wrap coinciding with an OUT commit shows the new out_reg on the new digit.
- An OUT while the display is mid-scan does not reset the scan index.
- The DIGITS==1 case keeps digit constantly 1.

## Configuration
- `FEMTO_SEG7_EN` defined:
  - seg carries the 7-segment hex glyph of the current nibble (0 = 0111111, 6 = 1111101, 1 = 0000110, F = 1110001).
- Undefined:
  - seg[3:0] carries the raw nibble and seg[6:4] = 0.
  - The decoder is not instantiated.

## Structure
- Package `femto_pkg` holds:
  - the opcode localparams (OP_NOP..OP_OUT);
  - the instruction field offset functions of NUMRF;
  - the ceil-div helper for DIGITS.
- One sub-module, `femto_seg7_dec`: a combinational nibble-to-glyph decoder, instantiated only under FEMTO_SEG7_EN.
- The register file, ALU and scan counter stay inline.

## Test plan
All scenarios use WIDTH=8, NUMRF=2, DIV_W=2 and FEMTO_SEG7_EN defined.
- LDI shift-in: LDI r1,#2 then LDI r1,#3 -> r1=0x0B. Then ADD r1,r1 -> r1=0x16, Z=0, C=0.
- Forwarding: back-to-back LDI r0,#3 then ADD r0,r0 -> r0=0x06 one edge after the ADD, no stall.
- SUB/XOR: r2=0, SUB r2,r0 (r0=6) -> r2=0xFA, C=1, Z=0. Then XOR r2,r2 -> r2=0, Z=1, C=0.
- Overflow: r3=0xFF, r0=0x01, ADD r3,r0 -> r3=0x00, Z=1, C=1. A following MOV leaves Z=1, C=1.
- Display: OUT r1 (0x16) -> out_valid pulses once, then:
  - digit=01, seg=1111101;
  - after 4 cycles, digit=10, seg=0000110;
  - after 4 more, back to digit=01.
- Reset mid-op: ADD sampled on the same edge as rst=1 -> all registers 0, flags 0, digit=01, seg=0111111, out_valid never pulses.
